// File: rtl/ssr_pkg.sv
// Shared types and default codec table for the codec configuration sequencer.
// Provides the FSM state enum, the table entry struct and the table lookup helper.
package ssr_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        GAP   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } ssr_state_e;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_entry_t;

    localparam int unsigned DEFAULT_TABLE_LEN = 8;

    // Codec bring-up order: reset, power, interface format, sample rate, volumes, activate.
    localparam cfg_entry_t DEFAULT_TABLE [DEFAULT_TABLE_LEN] = '{
        '{reg_addr: 8'h1E, data: 8'h00},
        '{reg_addr: 8'h0C, data: 8'h00},
        '{reg_addr: 8'h0E, data: 8'h42},
        '{reg_addr: 8'h10, data: 8'h00},
        '{reg_addr: 8'h00, data: 8'h17},
        '{reg_addr: 8'h02, data: 8'h17},
        '{reg_addr: 8'h08, data: 8'h12},
        '{reg_addr: 8'h12, data: 8'h01}
    };

    function automatic cfg_entry_t table_entry(input logic [7:0] idx);
        cfg_entry_t e;
        if (idx < 8'(DEFAULT_TABLE_LEN)) begin
            e = DEFAULT_TABLE[idx[2:0]];
        end else begin
            e = '{reg_addr: idx, data: 8'h00};
        end
        return e;
    endfunction

endpackage

// File: rtl/ssr_cfg_seq_if.sv
// Command/response bus between the configuration sequencer and the I2C master.
// master = sequencer side, slave = I2C master side.
interface ssr_cfg_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_nack;

    modport master (
        output cmd_valid, cmd_dev, cmd_reg, cmd_data,
        input  cmd_ready, rsp_valid, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd_dev, cmd_reg, cmd_data,
        output cmd_ready, rsp_valid, rsp_nack
    );
endinterface

// File: rtl/ssr_cfg_rom.sv
// Configuration table with a single registered read port.
// The output register holds its value until the next enabled read.
module ssr_cfg_rom
    import ssr_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output cfg_entry_t    rd_data_o
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_REGS - 1);

    cfg_entry_t rd_data_q;

    // Registered table read; addresses past the table return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            if (rd_addr_i <= LAST_ADDR) begin
                rd_data_q <= table_entry(8'(rd_addr_i));
            end else begin
                rd_data_q <= '0;
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ssr_cfg_seq.sv
// Codec configuration sequencer: walks the register table and issues one I2C
// write per entry, with bounded retries on NACK and a fixed idle gap between commands.
module ssr_cfg_seq
    import ssr_pkg::*;
#(
    parameter int         NUM_REGS   = 8,
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int         MAX_RETRY  = 2,
    parameter int         GAP_CYCLES = 100
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    ssr_cfg_seq_if.master               bus,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [$clog2(NUM_REGS)-1:0] err_idx
);

    localparam int IW = $clog2(NUM_REGS);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = $clog2(GAP_CYCLES + 2);

    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_REGS - 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    // A zero gap still costs one cycle in GAP.
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    ssr_state_e    state_q;
    logic [IW-1:0] idx_q;
    logic [IW-1:0] err_idx_q;
    logic [RW-1:0] retry_q;
    logic [GW-1:0] gap_cnt_q;
    logic          cmd_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    cfg_entry_t    rom_data_s;
    logic          rom_rd_en_s;

    assign rom_rd_en_s = (state_q == LOAD);

    ssr_cfg_rom #(
        .NUM_REGS (NUM_REGS),
        .AW       (IW)
    ) u_rom (
        .clk       (clk),
        .rst       (rst),
        .rd_en_i   (rom_rd_en_s),
        .rd_addr_i (idx_q),
        .rd_data_o (rom_data_s)
    );

    // Sequencer FSM with registered status and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            err_idx_q   <= '0;
            retry_q     <= '0;
            gap_cnt_q   <= '0;
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_q   <= LOAD;
                        idx_q     <= '0;
                        retry_q   <= '0;
                        done_q    <= 1'b0;
                        err_q     <= 1'b0;
                        err_idx_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q     <= ISSUE;
                    cmd_valid_q <= 1'b1;
                end
                ISSUE: begin
                    if (bus.cmd_ready) begin
                        state_q     <= WAIT;
                        cmd_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.rsp_valid) begin
                        if (!bus.rsp_nack) begin
                            if (idx_q == LAST_IDX) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q   <= GAP;
                                idx_q     <= idx_q + IW'(1);
                                retry_q   <= '0;
                                gap_cnt_q <= '0;
                            end
                        end else if (retry_q < RETRY_LIM) begin
                            state_q   <= GAP;
                            retry_q   <= retry_q + RW'(1);
                            gap_cnt_q <= '0;
                        end else begin
                            state_q   <= ERR;
                            err_q     <= 1'b1;
                            err_idx_q <= idx_q;
                            busy_q    <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q >= GAP_LAST) begin
                        state_q <= LOAD;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_dev   = DEV_ADDR;
    assign bus.cmd_reg   = rom_data_s.reg_addr;
    assign bus.cmd_data  = rom_data_s.data;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign err_idx       = err_idx_q;

endmodule

// File: tb/tb_ssr_cfg_seq.sv
// Scoreboard bench for ssr_cfg_seq: a responder models the I2C master, a monitor
// checks every accepted command against the queue filled from the table/retry model.
module tb_ssr_cfg_seq;

    localparam int         N    = 8;
    localparam int         MAXR = 2;
    localparam int         GAP  = 100;
    localparam logic [6:0] DEV  = 7'h1A;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, err;
    logic [2:0] err_idx;

    ssr_cfg_seq_if bus();

    ssr_cfg_seq #(
        .NUM_REGS   (N),
        .DEV_ADDR   (DEV),
        .MAX_RETRY  (MAXR),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_idx (err_idx)
    );

    always #5 clk = ~clk;

    // Expected codec table, written out independently of the design package.
    logic [7:0] ref_reg [N] = '{8'h1E, 8'h0C, 8'h0E, 8'h10, 8'h00, 8'h02, 8'h08, 8'h12};
    logic [7:0] ref_dat [N] = '{8'h00, 8'h00, 8'h42, 8'h00, 8'h17, 8'h17, 8'h12, 8'h01};

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
    } cmd_t;

    cmd_t       exp_q[$];
    int         checks     = 0;
    int         errors     = 0;
    int         nack_left [N] = '{default: 0};
    int         ready_mode = 0;
    int         hold_cnt   = 0;
    bit         stray_en   = 1'b0;
    bit         slow_rsp   = 1'b0;
    int         resp_cnt   = 0;
    logic [7:0] resp_reg   = 8'h00;
    int         acc_count  = 0;
    int         cyc        = 0;
    int         last_acc   = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int entry_of(input logic [7:0] r);
        for (int i = 0; i < N; i++) begin
            if (ref_reg[i] == r) return i;
        end
        return 0;
    endfunction

    // I2C master model: backpressure, delayed responses, NACK plan, stray pulses.
    initial begin
        bit         will_acc;
        logic [7:0] cur_reg;
        int         e;
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_nack  = 1'b0;
        forever begin
            @(negedge clk);
            will_acc = bus.cmd_valid && bus.cmd_ready && !rst;
            cur_reg  = bus.cmd_reg;
            @(posedge clk);
            #1;
            bus.rsp_valid = 1'b0;
            bus.rsp_nack  = 1'($urandom_range(0, 1));
            if (rst) begin
                resp_cnt = 0;
            end else if (will_acc) begin
                resp_cnt = slow_rsp ? 12 : int'($urandom_range(1, 6));
                resp_reg = cur_reg;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    e = entry_of(resp_reg);
                    bus.rsp_valid = 1'b1;
                    if (nack_left[e] > 0) begin
                        bus.rsp_nack = 1'b1;
                        nack_left[e]--;
                    end else begin
                        bus.rsp_nack = 1'b0;
                    end
                end
            end else if (stray_en && $urandom_range(0, 15) == 0) begin
                bus.rsp_valid = 1'b1;
            end
            case (ready_mode)
                0: bus.cmd_ready = 1'b1;
                1: bus.cmd_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (bus.cmd_valid && hold_cnt < 20) begin
                        bus.cmd_ready = 1'b0;
                        hold_cnt++;
                    end else begin
                        bus.cmd_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every accepted command, checks stall stability and spacing.
    initial begin
        bit         stalled = 1'b0;
        logic [22:0] held;
        cmd_t       c;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst || !bus.cmd_valid) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    chk("stall_stable", 32'(held), 32'({bus.cmd_dev, bus.cmd_reg, bus.cmd_data}));
                end
                if (bus.cmd_ready) begin
                    acc_count++;
                    stalled = 1'b0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd actual=reg %0h data %0h required=no command",
                                 bus.cmd_reg, bus.cmd_data);
                    end else begin
                        c = exp_q.pop_front();
                        chk("cmd_fields", 32'({bus.cmd_dev, bus.cmd_reg, bus.cmd_data}),
                            32'({DEV, c.r, c.d}));
                    end
                    if (last_acc >= 0) begin
                        chk("cmd_spacing_ge100", 32'(cyc - last_acc >= GAP), 32'd1);
                    end
                    last_acc = cyc;
                end else if (!stalled) begin
                    stalled = 1'b1;
                    held    = {bus.cmd_dev, bus.cmd_reg, bus.cmd_data};
                end
            end
        end
    end

    // Build the expected command list from the NACK plan, run one sequence and check the outcome.
    task automatic run_seq(input string tag, input bit noise);
        int plan [N];
        int nexp;
        bit exp_err;
        int exp_eidx;
        int cnt;
        plan     = nack_left;
        nexp     = 0;
        exp_err  = 1'b0;
        exp_eidx = 0;
        for (int i = 0; i < N; i++) begin
            int tries;
            tries = (plan[i] > MAXR) ? MAXR + 1 : plan[i] + 1;
            for (int k = 0; k < tries; k++) begin
                exp_q.push_back('{ref_reg[i], ref_dat[i]});
                nexp++;
            end
            if (plan[i] > MAXR) begin
                exp_err  = 1'b1;
                exp_eidx = i;
                break;
            end
        end
        acc_count = 0;
        last_acc  = -1;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_busy_in_load"}, 32'(busy), 32'd1);
        chk({tag, "_status_cleared"}, 32'({done, err, err_idx}), 32'd0);
        chk({tag, "_valid_not_yet"}, 32'(bus.cmd_valid), 32'd0);
        @(negedge clk);
        chk({tag, "_valid_2cyc"}, 32'(bus.cmd_valid), 32'd1);
        for (cnt = 0; cnt < 20000; cnt++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (!busy) break;
            if (noise && $urandom_range(0, 149) == 0) start = 1'b1;
        end
        chk({tag, "_finished_in_budget"}, 32'(cnt < 20000), 32'd1);
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'(!exp_err));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        chk({tag, "_err_idx"}, 32'(err_idx), exp_err ? 32'(exp_eidx) : 32'd0);
        chk({tag, "_idle_outputs"}, 32'({busy, bus.cmd_valid}), 32'd0);
        repeat (20) @(negedge clk);
        chk({tag, "_all_cmds_seen"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_accept_count"}, 32'(acc_count), 32'(nexp));
        exp_q.delete();
    endtask

    task automatic clear_plan();
        for (int i = 0; i < N; i++) nack_left[i] = 0;
    endtask

    initial begin
        int cnt;
        rst   = 1'b1;
        start = 1'b0;
        #12;
        chk("rst_status", 32'({busy, done, err, err_idx}), 32'd0);
        chk("rst_cmd", 32'({bus.cmd_valid, bus.cmd_reg, bus.cmd_data}), 32'd0);
        chk("rst_dev", 32'(bus.cmd_dev), 32'(DEV));
        @(posedge clk);
        #1;
        rst = 1'b0;

        clear_plan();
        ready_mode = 0;
        run_seq("nominal", 1'b0);

        clear_plan();
        ready_mode = 2;
        hold_cnt   = 0;
        run_seq("backpressure", 1'b0);
        chk("backpressure_held_20", 32'(hold_cnt), 32'd20);

        clear_plan();
        ready_mode   = 0;
        nack_left[3] = 2;
        run_seq("retry", 1'b0);

        clear_plan();
        nack_left[5] = 3;
        run_seq("abort", 1'b0);

        clear_plan();
        nack_left[1] = 1;
        ready_mode   = 1;
        stray_en     = 1'b1;
        run_seq("noise", 1'b1);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                int v;
                v = int'($urandom_range(0, 9));
                nack_left[i] = (v < 6) ? 0 : (v < 8) ? 1 : (v < 9) ? 2 : 3;
            end
            ready_mode = int'($urandom_range(0, 1));
            run_seq($sformatf("rand%0d", r), 1'b1);
        end

        // Reset while waiting for a response, then a fresh run from entry 0.
        clear_plan();
        stray_en   = 1'b0;
        ready_mode = 0;
        slow_rsp   = 1'b1;
        for (int i = 0; i < N; i++) exp_q.push_back('{ref_reg[i], ref_dat[i]});
        acc_count = 0;
        last_acc  = -1;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (cnt = 0; cnt < 2000; cnt++) begin
            if (acc_count >= 3) break;
            @(posedge clk);
            #1;
        end
        chk("midrun_reached_wait", 32'(cnt < 2000), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_status", 32'({busy, done, err, err_idx}), 32'd0);
        chk("midrun_rst_cmd", 32'({bus.cmd_valid, bus.cmd_reg, bus.cmd_data}), 32'd0);
        chk("midrun_rst_dev", 32'(bus.cmd_dev), 32'(DEV));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        slow_rsp = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrun_stays_idle", 32'({busy, bus.cmd_valid, done}), 32'd0);
        run_seq("after_reset", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssr_cfg_seq.md
SSR_CFG_SEQ -- requirements
Module: ssr_cfg_seq

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 8: number of codec register writes in the configuration table.
REQ-002 The block SHALL have parameter DEV_ADDR, default 7'h1A: 7-bit I2C device address placed on every command.
REQ-003 The block SHALL have parameter MAX_RETRY, default 2: number of reissues allowed per entry after a NACK.
REQ-004 The block SHALL have parameter GAP_CYCLES, default 100: idle clock cycles between consecutive commands.
REQ-005 The block SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 The block SHALL have port start, input, 1: single-cycle pulse (debounced button) requesting a configuration run.
REQ-008 The block SHALL have port cmd_valid, output, 1: command to the I2C master is valid.
REQ-009 The block SHALL have port cmd_ready, input, 1: I2C master accepts the command.
REQ-010 The block SHALL have port cmd_dev, output, 7: device address (DEV_ADDR).
REQ-011 The block SHALL have port cmd_reg, output, 8: codec register address.
REQ-012 The block SHALL have port cmd_data, output, 8: codec register data.
REQ-013 The block SHALL have port rsp_valid, input, 1: one-cycle pulse, I2C transaction finished.
REQ-014 The block SHALL have port rsp_nack, input, 1: qualified by rsp_valid; 1 means the slave NACKed.
REQ-015 The block SHALL have port busy, output, 1: run in progress.
REQ-016 The block SHALL have port done, output, 1: sticky, last run completed with all entries ACKed.
REQ-017 The block SHALL have port err, output, 1: sticky, last run aborted.
REQ-018 The block SHALL have port err_idx, output, $clog2(NUM_REGS): table index that failed.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, ISSUE, WAIT, GAP, DONE, ERR.
REQ-020 start in IDLE, DONE or ERR SHALL move to LOAD next cycle, set idx=0, retry=0, and clear done, err and err_idx; start in any other state SHALL be ignored.
REQ-021 LOAD SHALL read entry idx from the table (1-cycle registered read) and go to ISSUE, so cmd_valid rises 2 cycles after start.
REQ-022 In ISSUE, cmd_valid SHALL be 1 and cmd_dev/cmd_reg/cmd_data SHALL be stable until the cycle where cmd_valid && cmd_ready, after which the FSM SHALL enter WAIT with cmd_valid 0.
REQ-023 In WAIT, rsp_valid with rsp_nack=0 SHALL go to DONE if idx==NUM_REGS-1, otherwise to GAP with idx+1 and retry=0.
REQ-024 In WAIT, rsp_valid with rsp_nack=1 and retry<MAX_RETRY SHALL go to GAP with retry+1 and idx unchanged.
REQ-025 In WAIT, rsp_valid with rsp_nack=1 and retry==MAX_RETRY SHALL go to ERR, latching err_idx=idx.
REQ-026 rsp_valid outside WAIT SHALL be ignored; rsp_nack SHALL be ignored when rsp_valid=0.
REQ-027 GAP SHALL last exactly GAP_CYCLES cycles, then go to LOAD; with GAP_CYCLES=0 it SHALL last 1 cycle.
REQ-028 busy SHALL be 1 in LOAD, ISSUE, WAIT and GAP, and 0 otherwise.
REQ-029 done SHALL set on entry to DONE and err SHALL set on entry to ERR; both SHALL hold until the next accepted start or reset.
REQ-030 Index and retry counters SHALL saturate at their bounds and never wrap.

Reset
REQ-031 Reset SHALL force IDLE, with cmd_valid, busy, done, err, err_idx, cmd_reg and cmd_data at 0 and cmd_dev at DEV_ADDR, asynchronously.
REQ-032 Reset mid-run SHALL abandon the run, with no further command issued, including while cmd_valid is high.

Structure
REQ-033 A shared package ssr_pkg SHALL hold the FSM state enum, the cfg_entry_t struct {reg, data} and the default codec table constant.
REQ-034 The table SHALL be a sub-module ssr_cfg_rom (NUM_REGS entries, registered read port).

Verification
REQ-035 Nominal: start, cmd_ready tied 1, 8 ACK responses -> 8 commands with table values, ≥100 cycles apart, then done=1, busy=0, err=0.
REQ-036 Backpressure: cmd_ready held 0 for 20 cycles -> cmd_valid held high with constant fields, exactly one accept.
REQ-037 Retry: NACK on entry 3 twice then ACK -> entry 3 issued 3 times, then done=1.
REQ-038 Abort: NACK on entry 5 three times -> err=1, err_idx=5, no 7th command, done=0.
REQ-039 start pulses during busy and stray rsp_valid in GAP -> ignored, and the sequence is unchanged.
REQ-040 rst asserted in WAIT -> all outputs 0 the same cycle; a new start then runs the full sequence from entry 0.
